// File: rtl/sseg_sched_pkg.sv
// Shared types, constants and the round-robin pick helper for the page scheduler.
package sseg_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    // Active-low decimal points: all off.
    localparam logic [3:0] DP_OFF = 4'hF;

    // Upper bound on requesters; page index is always 3 bits wide.
    localparam int unsigned MAX_SRC = 8;
    localparam int unsigned IDX_W   = 3;

    // Round-robin search starting at (last+1) mod n, wrapping; first set req wins.
    // Returns last when nothing requests (caller qualifies with an 'any' flag).
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_SRC-1:0] req,
        input logic [IDX_W-1:0]   last,
        input int unsigned        n
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W:0]   sum;
        pick = last;
        // Walk from the farthest candidate back to the nearest so the nearest wins.
        for (int unsigned k = MAX_SRC; k > 0; k--) begin
            if (k <= n) begin
                sum = {1'b0, last} + (IDX_W+1)'(k);
                // last < n and k <= n, so one subtraction is enough to wrap.
                if (sum >= (IDX_W+1)'(n)) begin
                    sum = sum - (IDX_W+1)'(n);
                end
                if (req[IDX_W'(sum)]) begin
                    pick = IDX_W'(sum);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, binary index and any-request flag.
module rr_arbiter
    import sseg_sched_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [MAX_SRC-1:0] req_ext;

    // Widen the request vector to the helper's fixed width and pick the winner.
    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        any            = |req;
        idx            = rr_pick(req_ext, last, N);
        grant          = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/sseg_page_scheduler.sv
// Round-robin pager sharing a 4-digit seven-segment display between several requesters.
// Each granted page is shown for DWELL_CYCLES, followed by BLANK_CYCLES of blank display.
module sseg_page_scheduler
    import sseg_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DWELL_CYCLES = 100_000_000,
    parameter int unsigned BLANK_CYCLES = 10_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC-1:0]     req,
    input  logic [NUM_SRC*16-1:0]  src_hex,
    input  logic [NUM_SRC*4-1:0]   src_dp,
    input  logic                   next,
    input  logic                   pin,
    output logic [3:0]             hex0,
    output logic [3:0]             hex1,
    output logic [3:0]             hex2,
    output logic [3:0]             hex3,
    output logic [3:0]             dp_out,
    output logic                   disp_en,
    output logic [NUM_SRC-1:0]     grant,
    output logic [2:0]             page
);

    localparam int unsigned TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    // Timer holds "cycles remaining after this one", so a load of N-1 gives N cycles.
    localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYCLES - 1);

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IDX_W-1:0]     page_q, page_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic                 started_q, started_d;
    logic [15:0]          hex_q, hex_d;
    logic [3:0]           dp_q, dp_d;

    logic [IDX_W-1:0]     arb_last;
    logic [NUM_SRC-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 owner_req;
    logic                 show_leave;

    // Before the first grant the search starts at source 0, so pretend the last
    // owner was the highest index; afterwards it follows the real page.
    assign arb_last = started_q ? page_q : IDX_W'(NUM_SRC - 1);

    rr_arbiter #(
        .N (NUM_SRC)
    ) u_arb (
        .req   (req),
        .last  (arb_last),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // grant_q is only non-zero in SHOW, so this is the current owner's request.
    assign owner_req  = |(req & grant_q);
    // Owner release overrides pin; pin only blocks the dwell expiry.
    assign show_leave = ((timer_q == '0) && !pin) || next || !owner_req;

    // State register with page, grant and dwell/blank timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            page_q    <= '0;
            grant_q   <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            page_q    <= page_d;
            grant_q   <= grant_d;
            started_q <= started_d;
        end
    end

    // Next-state logic: arbitration, dwell countdown and blank gap.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        page_d    = page_q;
        grant_d   = grant_q;
        started_d = started_q;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (arb_any) begin
                    state_d   = SHOW;
                    page_d    = arb_idx;
                    grant_d   = arb_grant;
                    started_d = 1'b1;
                    timer_d   = DWELL_LOAD;
                end
            end
            SHOW: begin
                if (show_leave) begin
                    state_d = GAP;
                    grant_d = '0;
                    timer_d = BLANK_LOAD;
                end else if (!pin && (timer_q != '0)) begin
                    timer_d = timer_q - 1'b1;
                end
            end
            GAP: begin
                grant_d = '0;
                if (timer_q == '0) begin
                    if (arb_any) begin
                        state_d = SHOW;
                        page_d  = arb_idx;
                        grant_d = arb_grant;
                        timer_d = DWELL_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                timer_d = '0;
            end
        endcase
    end

    // Data path select: follow the owner live while showing, else hold digits and blank dp.
    always_comb begin
        hex_d = hex_q;
        dp_d  = DP_OFF;
        if (state_d == SHOW) begin
            hex_d = 16'(src_hex >> {page_d, 4'b0000});
            dp_d  = 4'(src_dp >> {page_d, 2'b00});
        end
    end

    // Output register bank for digits and decimal points.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_q <= '0;
            dp_q  <= DP_OFF;
        end else begin
            hex_q <= hex_d;
            dp_q  <= dp_d;
        end
    end

    // Output decode: everything derives from registered state so it moves with it.
    always_comb begin
        disp_en = (state_q == SHOW);
        grant   = grant_q;
        page    = page_q;
        hex0    = hex_q[3:0];
        hex1    = hex_q[7:4];
        hex2    = hex_q[11:8];
        hex3    = hex_q[15:12];
        dp_out  = dp_q;
    end

endmodule

// File: tb/tb_sseg_page_scheduler.sv
// Directed bench for the page scheduler with short dwell/blank times.
module tb_sseg_page_scheduler;

    localparam int unsigned NUM_SRC = 4;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_SRC-1:0]    req;
    logic [NUM_SRC*16-1:0] src_hex;
    logic [NUM_SRC*4-1:0]  src_dp;
    logic                  next;
    logic                  pin;
    logic [3:0]            hex0, hex1, hex2, hex3;
    logic [3:0]            dp_out;
    logic                  disp_en;
    logic [NUM_SRC-1:0]    grant;
    logic [2:0]            page;

    int checks = 0;
    int errors = 0;

    sseg_page_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .DWELL_CYCLES (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .src_hex (src_hex),
        .src_dp  (src_dp),
        .next    (next),
        .pin     (pin),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3),
        .dp_out  (dp_out),
        .disp_en (disp_en),
        .grant   (grant),
        .page    (page)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b1;
        req     = '0;
        next    = 1'b0;
        pin     = 1'b0;
        // src3=9ABC src2=5678 src1=00AB src0=1234
        src_hex = 64'h9ABC_5678_00AB_1234;
        // dp: src3=B src2=D src1=7 src0=E
        src_dp  = 16'hBD7E;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_disp_en", 16'(disp_en), 16'h0);
        chk("rst_grant",   16'(grant),   16'h0);
        chk("rst_dp",      16'(dp_out),  16'hF);
        chk("rst_page",    16'(page),    16'h0);
        chk("rst_hex",     {hex3, hex2, hex1, hex0}, 16'h0000);
        #19 rst_n = 1'b1;
        tick(1);
        chk("idle_disp_en", 16'(disp_en), 16'h0);

        // Two requesters: src0 first, then src2, then back to src0.
        req = 4'b0101;
        tick(1);
        chk("a_grant0",   16'(grant),   16'b0001);
        chk("a_disp_en",  16'(disp_en), 16'h1);
        chk("a_hex",      {hex3, hex2, hex1, hex0}, 16'h1234);
        chk("a_dp",       16'(dp_out),  16'hE);
        tick(7);
        chk("a_last_show", 16'(grant),  16'b0001);
        tick(1);
        chk("a_gap_disp",  16'(disp_en), 16'h0);
        chk("a_gap_grant", 16'(grant),   16'h0);
        chk("a_gap_dp",    16'(dp_out),  16'hF);
        chk("a_gap_hold",  16'(hex0),    16'h4);
        tick(1);
        chk("a_gap2_disp", 16'(disp_en), 16'h0);
        tick(1);
        chk("a_grant2",    16'(grant),   16'b0100);
        chk("a_page2",     16'(page),    16'h2);
        chk("a_hex2",      {hex3, hex2, hex1, hex0}, 16'h5678);
        chk("a_dp2",       16'(dp_out),  16'hD);
        tick(10);
        chk("a_back0",     16'(grant),   16'b0001);

        // Sole requester is re-granted after the gap.
        req = 4'b0001;
        tick(8);
        chk("b_gap_disp",  16'(disp_en), 16'h0);
        tick(2);
        chk("b_regrant",   16'(grant),   16'b0001);
        chk("b_disp_en",   16'(disp_en), 16'h1);

        // Pin holds src0 well beyond the dwell, then the rest of the dwell runs.
        req = 4'b0011;
        pin = 1'b1;
        tick(50);
        chk("c_pinned",    16'(grant),   16'b0001);
        pin = 1'b0;
        tick(7);
        chk("c_remaining", 16'(grant),   16'b0001);
        tick(1);
        chk("c_gap",       16'(disp_en), 16'h0);
        tick(2);
        chk("c_src1",      16'(grant),   16'b0010);
        chk("c_page1",     16'(page),    16'h1);
        chk("c_hex_ab",    {hex3, hex2, hex1, hex0}, 16'h00AB);

        // Owner's data changes follow one cycle later without re-grant.
        src_hex[31:16] = 16'h00CD;
        #1;
        chk("d_before",    16'(hex0),    16'hB);
        tick(1);
        chk("d_hex0",      16'(hex0),    16'hD);
        chk("d_hex1",      16'(hex1),    16'hC);
        chk("d_grant",     16'(grant),   16'b0010);

        // next during SHOW ends the page at the next edge; next in GAP is ignored.
        tick(1);
        chk("e_pre_next",  16'(disp_en), 16'h1);
        next = 1'b1;
        tick(1);
        next = 1'b0;
        chk("e_next_gap",  16'(disp_en), 16'h0);
        chk("e_next_gnt",  16'(grant),   16'h0);
        next = 1'b1;
        tick(1);
        next = 1'b0;
        chk("e_gap_next",  16'(disp_en), 16'h0);
        tick(1);
        chk("e_after_gap", 16'(grant),   16'b0001);

        // Owner release beats pin; then no requests returns to IDLE.
        pin = 1'b1;
        req = 4'b0010;
        tick(1);
        chk("f_release",   16'(disp_en), 16'h0);
        chk("f_rel_grant", 16'(grant),   16'h0);
        pin = 1'b0;
        tick(2);
        chk("f_other",     16'(grant),   16'b0010);
        req = 4'b0000;
        tick(3);
        chk("f_idle_disp", 16'(disp_en), 16'h0);
        chk("f_idle_gnt",  16'(grant),   16'h0);
        chk("f_idle_dp",   16'(dp_out),  16'hF);
        tick(3);
        chk("f_idle_stay", 16'(disp_en), 16'h0);

        // Reset in the middle of SHOW clears outputs without waiting for a clock.
        req = 4'b0100;
        tick(1);
        chk("g_show2",     16'(grant),   16'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("g_rst_disp",  16'(disp_en), 16'h0);
        chk("g_rst_grant", 16'(grant),   16'h0);
        chk("g_rst_dp",    16'(dp_out),  16'hF);
        chk("g_rst_hex0",  16'(hex0),    16'h0);
        #2 rst_n = 1'b1;
        tick(1);
        chk("g_after_rst", 16'(grant),   16'b0100);
        chk("g_page",      16'(page),    16'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
